// File: rtl/ram_banked_2r1w.sv
// ram_banked_2r1w: banked RAM with one write port, two registered read ports, and a clear-on-reset sweep
module ram_banked_2r1w #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int BANK_BITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] d_in,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] d_out_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] d_out_b,
    output logic              rd_valid_b
);
    localparam int NB = 1 << BANK_BITS;
    localparam int LW = ADDR_W - BANK_BITS;
    localparam int BW = (BANK_BITS > 0) ? BANK_BITS : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [LW-1:0]     init_cnt;
    logic              run;
    logic [BW-1:0]     wr_bank, bank_a, bank_b;
    logic [LW-1:0]     wr_idx, idx_a, idx_b;
    logic [DATA_W-1:0] q_a [NB];
    logic [DATA_W-1:0] q_b [NB];
    logic              hit_a, hit_b;

    assign run     = (state == RUN);
    // with a single bank the shift leaves nothing, so every address lands in bank 0
    assign wr_bank = BW'(wr_addr >> LW);
    assign bank_a  = BW'(rd_addr_a >> LW);
    assign bank_b  = BW'(rd_addr_b >> LW);
    assign wr_idx  = wr_addr[LW-1:0];
    assign idx_a   = rd_addr_a[LW-1:0];
    assign idx_b   = rd_addr_b[LW-1:0];
    assign hit_a   = wr_en && (wr_addr == rd_addr_a);
    assign hit_b   = wr_en && (wr_addr == rd_addr_b);

    // init sweep: one local index cleared per edge in all banks, then park in RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
        end else if (state == INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == {LW{1'b1}}) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NB; g++) begin : g_bank
            logic [DATA_W-1:0] mem [2**LW];
            logic              we;
            logic [LW-1:0]     wi;
            logic [DATA_W-1:0] wd;
            assign we = run ? (wr_en && wr_bank == BW'(g)) : 1'b1;
            assign wi = run ? wr_idx : init_cnt;
            assign wd = run ? d_in : '0;
            assign q_a[g] = mem[idx_a];
            assign q_b[g] = mem[idx_b];
            // bank storage: zero fill during INIT, user writes only when this bank is addressed in RUN
            always_ff @(posedge clk) begin
                if (we)
                    mem[wi] <= wd;
            end
        end
    endgenerate

    // registered read ports, write-first on an address collision
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out_a    <= '0;
            d_out_b    <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= run && rd_en_a;
            rd_valid_b <= run && rd_en_b;
            if (run && rd_en_a)
                d_out_a <= hit_a ? d_in : q_a[bank_a];
            if (run && rd_en_b)
                d_out_b <= hit_b ? d_in : q_b[bank_b];
        end
    end
endmodule

// File: tb/tb_ram_banked_2r1w.sv
// tb_ram_banked_2r1w: directed scoreboard bench for the 8x8 banked 2R1W RAM
module tb_ram_banked_2r1w;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ready;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [15:0] d_in = '0;
    logic        rd_en_a = 1'b0;
    logic [5:0]  rd_addr_a = '0;
    logic [15:0] d_out_a;
    logic        rd_valid_a;
    logic        rd_en_b = 1'b0;
    logic [5:0]  rd_addr_b = '0;
    logic [15:0] d_out_b;
    logic        rd_valid_b;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];

    ram_banked_2r1w #(.DATA_W(16), .ADDR_W(6), .BANK_BITS(3)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .d_in(d_in),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .d_out_a(d_out_a), .rd_valid_a(rd_valid_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .d_out_b(d_out_b), .rd_valid_b(rd_valid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every valid read must match the oldest expectation for that port
    always @(negedge clk) begin
        if (reset && rd_valid_a) begin
            if (exp_a.size() == 0) begin
                total++;
                bad++;
                $display("FAIL port_a_unexpected: got valid with data %h expected no read", d_out_a);
            end else
                chk("port_a_data", 32'(d_out_a), 32'(exp_a.pop_front()));
        end
        if (reset && rd_valid_b) begin
            if (exp_b.size() == 0) begin
                total++;
                bad++;
                $display("FAIL port_b_unexpected: got valid with data %h expected no read", d_out_b);
            end else
                chk("port_b_data", 32'(d_out_b), 32'(exp_b.pop_front()));
        end
    end

    task automatic op(input logic ae, input logic [5:0] aa, input logic [15:0] ax,
                      input logic be, input logic [5:0] ba, input logic [15:0] bx,
                      input logic we, input logic [5:0] wa, input logic [15:0] wd);
        rd_en_a = ae; rd_addr_a = aa;
        rd_en_b = be; rd_addr_b = ba;
        wr_en = we; wr_addr = wa; d_in = wd;
        if (ae) exp_a.push_back(ax);
        if (be) exp_b.push_back(bx);
        @(negedge clk);
    endtask

    task automatic idle();
        rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 20 && !ready; i++)
            @(negedge clk);
        chk(name, 32'(ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_valid", 32'({rd_valid_a, rd_valid_b}), 32'd0);
        chk("rst_dout", 32'({d_out_a, d_out_b}), 32'd0);
        // user traffic during INIT must be ignored
        wr_en = 1'b1; wr_addr = 6'h10; d_in = 16'hFFFF;
        rd_en_a = 1'b1; rd_addr_a = 6'h10;
        rd_en_b = 1'b1; rd_addr_b = 6'h10;
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("init_ready_%0d", i), 32'(ready), 32'd0);
        end
        @(negedge clk);
        chk("ready_after_8", 32'(ready), 32'd1);
        rd_en_a = 1'b0; rd_en_b = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        op(1, 6'h3F, 16'h0000, 1, 6'h10, 16'h0000, 0, 6'h00, 16'h0000);
        idle();
        op(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 1, 6'h2A, 16'hBEEF);
        op(1, 6'h2A, 16'hBEEF, 1, 6'h2A, 16'hBEEF, 0, 6'h00, 16'h0000);
        op(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 1, 6'h04, 16'h00AA);
        op(1, 6'h05, 16'h1234, 1, 6'h04, 16'h00AA, 1, 6'h05, 16'h1234);
        op(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 1, 6'h07, 16'h1111);
        op(0, 6'h00, 16'h0000, 0, 6'h00, 16'h0000, 1, 6'h08, 16'h2222);
        op(1, 6'h07, 16'h1111, 1, 6'h08, 16'h2222, 0, 6'h00, 16'h0000);
        op(1, 6'h06, 16'h0000, 1, 6'h09, 16'h0000, 0, 6'h00, 16'h0000);
        op(1, 6'h05, 16'h1234, 1, 6'h2A, 16'hBEEF, 0, 6'h00, 16'h0000);
        idle();
        chk("hold_valid", 32'({rd_valid_a, rd_valid_b}), 32'd0);
        chk("hold_dout_a", 32'(d_out_a), 32'h1234);
        chk("hold_dout_b", 32'(d_out_b), 32'hBEEF);
        // asynchronous reset in the middle of a cycle
        rd_en_a = 1'b1; rd_addr_a = 6'h2A;
        @(posedge clk);
        #1;
        chk("pre_rst_dout_a", 32'(d_out_a), 32'hBEEF);
        chk("pre_rst_valid_a", 32'(rd_valid_a), 32'd1);
        rd_en_a = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("async_rst_ready", 32'(ready), 32'd0);
        chk("async_rst_valid", 32'({rd_valid_a, rd_valid_b}), 32'd0);
        chk("async_rst_dout", 32'({d_out_a, d_out_b}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reinit_ready_low", 32'(ready), 32'd0);
        wait_ready("reinit_ready");
        op(1, 6'h2A, 16'h0000, 1, 6'h05, 16'h0000, 0, 6'h00, 16'h0000);
        op(1, 6'h08, 16'h0000, 1, 6'h07, 16'h0000, 0, 6'h00, 16'h0000);
        idle();
        idle();
        chk("q_a_drained", 32'(exp_a.size()), 32'd0);
        chk("q_b_drained", 32'(exp_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
